// File: rtl/mos6502_dispatch_core.sv
// 6502 cycle sequencer: two-phase clock, opcode latch, instruction-length decode
// and one-hot T-state stepping (T1..T6, T0) with optional page-cross extra cycle.
module mos6502_dispatch_core (
    input  logic       PHI0,
    input  logic       RST,
    input  logic       RDY,
    input  logic       ACR,
    input  logic [7:0] PD,
    output logic       PHI1,
    output logic       PHI2,
    output logic [7:0] IR,
    output logic       FETCH,
    output logic       Z_IR,
    output logic       T0,
    output logic       T1,
    output logic       T2,
    output logic       T3,
    output logic       T4,
    output logic       T5,
    output logic       n_T0,
    output logic       n_T1X,
    output logic       TRES2,
    output logic       n_ready
);

    logic [6:0] r_t;
    logic [2:0] r_idx;
    logic [2:0] r_len;
    logic       r_extra;
    logic [7:0] r_ir;
    logic       r_zir;

    logic [7:0] w_op;
    logic [2:0] w_len_new;
    logic       w_elig;
    logic [2:0] w_next_idx;
    logic       w_next_extra;

    function automatic logic [2:0] f_len(input logic [7:0] op);
        logic [2:0] aaa;
        logic [2:0] bbb;
        logic [1:0] cc;
        aaa = op[7:5];
        bbb = op[4:2];
        cc  = op[1:0];
        f_len = 3'd2;
        if (op == 8'h00) begin
            f_len = 3'd7;
        end else if (op == 8'h20 || op == 8'h40 || op == 8'h60) begin
            f_len = 3'd6;
        end else if (op == 8'h4C || op == 8'h08 || op == 8'h48) begin
            f_len = 3'd3;
        end else if (op == 8'h6C) begin
            f_len = 3'd5;
        end else if (op == 8'h28 || op == 8'h68) begin
            f_len = 3'd4;
        end else if (op[4:0] == 5'b10000) begin
            f_len = 3'd2;
        end else if (op[3:0] == 4'h8 || op[3:0] == 4'hA) begin
            f_len = 3'd2;
        end else if (cc == 2'b01) begin
            case (bbb)
                3'b000:         f_len = 3'd6;
                3'b001:         f_len = 3'd3;
                3'b010:         f_len = 3'd2;
                3'b011, 3'b101: f_len = 3'd4;
                3'b100:         f_len = (aaa == 3'b100) ? 3'd6 : 3'd5;
                default:        f_len = (aaa == 3'b100) ? 3'd5 : 3'd4;
            endcase
        end else if (cc != 2'b11) begin
            case (bbb)
                3'b001:                 f_len = 3'd3;
                3'b011, 3'b101, 3'b111: f_len = 3'd4;
                default:                f_len = 3'd2;
            endcase
            // Read-modify-write: zp 5, abs 6, zp,X 6, abs,X 7.
            if (cc == 2'b10 && aaa != 3'b100 && aaa != 3'b101 && bbb[0]) begin
                f_len = (bbb == 3'b111) ? 3'd7 : f_len + 3'd2;
            end
        end
    endfunction

    assign w_op      = r_zir ? 8'h00 : PD;
    assign w_len_new = f_len(w_op);
    assign w_elig    = (r_ir[1:0] == 2'b01 && r_ir[7:5] != 3'b100 &&
                        (r_ir[4:2] == 3'b100 || r_ir[4:2] == 3'b110 || r_ir[4:2] == 3'b111)) ||
                       (r_ir[7:2] == 6'b101111 && !r_ir[0]);

    always_comb begin
        w_next_idx   = r_idx + 3'd1;
        w_next_extra = r_extra;
        if (r_idx == 3'd0) begin
            w_next_idx   = 3'd1;
            w_next_extra = 1'b0;
        end else if (r_idx == 3'd1) begin
            w_next_idx = (w_len_new == 3'd2) ? 3'd0 : 3'd2;
        end else if (r_extra) begin
            w_next_idx   = 3'd0;
            w_next_extra = 1'b0;
        end else if (r_idx == r_len - 3'd1) begin
            // Page cross on the last cycle inserts one more T-state before T0.
            if (w_elig && ACR) begin
                w_next_extra = 1'b1;
            end else begin
                w_next_idx = 3'd0;
            end
        end
    end

    always_ff @(posedge PHI0) begin
        if (RST) begin
            r_idx   <= 3'd0;
            r_t     <= 7'b0000001;
            r_ir    <= 8'h00;
            r_zir   <= 1'b1;
            r_len   <= 3'd2;
            r_extra <= 1'b0;
        end else if (RDY) begin
            r_idx   <= w_next_idx;
            r_t     <= 7'b0000001 << w_next_idx;
            r_extra <= w_next_extra;
            if (r_idx == 3'd1) begin
                r_ir  <= w_op;
                r_zir <= 1'b0;
                r_len <= w_len_new;
            end
        end
    end

    assign PHI1    = ~PHI0;
    assign PHI2    = PHI0;
    assign IR      = r_ir;
    assign Z_IR    = r_zir;
    assign T0      = r_t[0];
    assign T1      = r_t[1];
    assign T2      = r_t[2];
    assign T3      = r_t[3];
    assign T4      = r_t[4];
    assign T5      = r_t[5];
    assign n_T0    = ~r_t[0];
    assign n_T1X   = ~r_t[1];
    assign FETCH   = r_t[1] & RDY;
    assign TRES2   = r_t[0] & RDY;
    assign n_ready = ~RDY;

endmodule

// File: tb/tb_mos6502_dispatch_core.sv
// Scoreboard bench for mos6502_dispatch_core: stimulus pushes expected per-cycle
// outputs from an instruction-level model, a monitor pops and compares them.
module tb_mos6502_dispatch_core;

    logic       PHI0, RST, RDY, ACR;
    logic [7:0] PD;
    logic       PHI1, PHI2, FETCH, Z_IR, T0, T1, T2, T3, T4, T5, n_T0, n_T1X, TRES2, n_ready;
    logic [7:0] IR;

    mos6502_dispatch_core dut (
        .PHI0(PHI0), .RST(RST), .RDY(RDY), .ACR(ACR), .PD(PD),
        .PHI1(PHI1), .PHI2(PHI2), .IR(IR), .FETCH(FETCH), .Z_IR(Z_IR),
        .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5),
        .n_T0(n_T0), .n_T1X(n_T1X), .TRES2(TRES2), .n_ready(n_ready)
    );

    typedef struct packed {
        logic [5:0] t;
        logic       n_t0;
        logic       n_t1x;
        logic       fetch;
        logic       tres2;
        logic       n_rdy;
        logic       zir;
        logic [7:0] ir;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Instruction-level model: current T number plus the remaining T-states planned.
    int   m_t = 0;
    logic [7:0] m_ir = 8'h00;
    logic m_zir = 1'b1;
    logic m_elig = 1'b0;
    logic m_ins = 1'b0;
    int   m_plan[$];

    function automatic int ref_len(input logic [7:0] op);
        int a, b, c, n;
        int t01[8];
        int t02[8];
        a = int'(op[7:5]);
        b = int'(op[4:2]);
        c = int'(op[1:0]);
        t01 = '{6, 3, 2, 4, 5, 4, 4, 4};
        t02 = '{2, 3, 2, 4, 2, 4, 2, 4};
        case (op)
            8'h00: return 7;
            8'h20, 8'h40, 8'h60: return 6;
            8'h4C, 8'h08, 8'h48: return 3;
            8'h6C: return 5;
            8'h28, 8'h68: return 4;
            default: ;
        endcase
        if ((op & 8'h1F) == 8'h10) return 2;
        if (op[3:0] == 4'h8 || op[3:0] == 4'hA) return 2;
        if (c == 3) return 2;
        if (c == 1) begin
            n = t01[b];
            if (a == 4 && (b == 4 || b == 6 || b == 7)) n = n + 1;
            return n;
        end
        n = t02[b];
        if (c == 2 && a != 4 && a != 5 && (b % 2) == 1) n = (b == 1) ? 5 : ((b == 7) ? 7 : 6);
        return n;
    endfunction

    function automatic logic ref_elig(input logic [7:0] op);
        int a, b, c;
        a = int'(op[7:5]);
        b = int'(op[4:2]);
        c = int'(op[1:0]);
        return (c == 1 && a != 4 && (b == 4 || b == 6 || b == 7)) ||
               ((c == 0 || c == 2) && a == 5 && b == 7);
    endfunction

    task automatic model_step(input logic rst, input logic rdy, input logic acr,
                              input logic [7:0] pd);
        logic [7:0] op;
        int l;
        if (rst) begin
            m_t = 0; m_ir = 8'h00; m_zir = 1'b1; m_elig = 1'b0; m_ins = 1'b0;
            m_plan.delete();
        end else if (rdy) begin
            if (m_t == 0) begin
                m_t = 1;
            end else if (m_t == 1) begin
                op = m_zir ? 8'h00 : pd;
                m_ir = op; m_zir = 1'b0; m_ins = 1'b0;
                m_elig = ref_elig(op);
                l = ref_len(op);
                m_plan.delete();
                for (int k = 2; k < l; k++) m_plan.push_back(k);
                m_plan.push_back(0);
                m_t = m_plan.pop_front();
            end else if (m_elig && acr && !m_ins && m_plan.size() == 1) begin
                m_t = m_t + 1;
                m_ins = 1'b1;
            end else if (m_plan.size() > 0) begin
                m_t = m_plan.pop_front();
            end else begin
                m_t = 0;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic rdy, input logic acr, input logic [7:0] pd);
        exp_t e;
        @(negedge PHI0);
        RST = rst; RDY = rdy; ACR = acr; PD = pd;
        e.t     = (m_t <= 5) ? 6'(1 << m_t) : 6'd0;
        e.n_t0  = (m_t != 0);
        e.n_t1x = (m_t != 1);
        e.fetch = (m_t == 1) && rdy;
        e.tres2 = (m_t == 0) && rdy;
        e.n_rdy = !rdy;
        e.zir   = m_zir;
        e.ir    = m_ir;
        exp_q.push_back(e);
        model_step(rst, rdy, acr, pd);
    endtask

    initial begin
        PHI0 = 1'b0;
        forever #5 PHI0 = ~PHI0;
    end

    // Monitor: every cycle's outputs are the DUT's response; compare against the queue.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge PHI0);
            #2;
            n_tests++;
            if ({PHI2, PHI1} !== 2'b01) begin
                n_fail++;
                $display("FAIL phi_low: got PHI2/PHI1=%b%b need 01 at %0t", PHI2, PHI1, $time);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {{T5, T4, T3, T2, T1, T0}, n_T0, n_T1X, FETCH, TRES2, n_ready, Z_IR, IR};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs at %0t: got T=%b nT0=%b nT1X=%b FETCH=%b TRES2=%b nrdy=%b Z_IR=%b IR=%h; need T=%b nT0=%b nT1X=%b FETCH=%b TRES2=%b nrdy=%b Z_IR=%b IR=%h",
                             $time, got.t, got.n_t0, got.n_t1x, got.fetch, got.tres2, got.n_rdy,
                             got.zir, got.ir, e.t, e.n_t0, e.n_t1x, e.fetch, e.tres2, e.n_rdy,
                             e.zir, e.ir);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge PHI0);
            #1;
            n_tests++;
            if ({PHI2, PHI1} !== 2'b10) begin
                n_fail++;
                $display("FAIL phi_high: got PHI2/PHI1=%b%b need 10 at %0t", PHI2, PHI1, $time);
            end
        end
    end

    initial begin
        int guard;
        RST = 1'b1; RDY = 1'b1; ACR = 1'b0; PD = 8'h8D;
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 8'h8D);
        repeat (30) cycle(1'b0, 1'b1, 1'b0, 8'h8D);
        repeat (12) cycle(1'b0, 1'b1, 1'b0, 8'hEA);
        repeat (15) cycle(1'b0, 1'b1, 1'b1, 8'hBD);
        repeat (12) cycle(1'b0, 1'b1, 1'b0, 8'hBD);
        repeat (24) cycle(1'b0, 1'b1, 1'($urandom_range(1)), 8'h91);
        guard = 0;
        while (m_t != 2 && guard < 20) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h8D);
            guard++;
        end
        n_tests++;
        if (m_t != 2) begin
            n_fail++;
            $display("FAIL stall_setup: model T=%0d need 2 within 20 cycles", m_t);
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h8D);
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 8'h8D);
        repeat (3000) begin
            cycle(1'($urandom_range(63) == 0), 1'($urandom_range(7) != 0),
                  1'($urandom_range(1)), 8'($urandom_range(255)));
        end
        @(negedge PHI0);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
